// File: rtl/mips_br_pkg.sv
// Shared definitions for the ID-stage branch unit: branch opcodes, FSM state
// encoding and the opcode-level resolution rules.
package mips_br_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5,
    BR_RSV6 = 3'd6,
    BR_RSV7 = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } br_state_e;

  // Only the two-register compares consume rt; everything else compares rs against zero.
  function automatic logic br_needs_rt(br_op_e op);
    return (op == BR_BEQ) || (op == BR_BNE);
  endfunction

  function automatic logic br_resolve(br_op_e op, logic eq, logic neg);
    logic taken;
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = ~eq;
      BR_BLEZ: taken = neg | eq;
      BR_BGTZ: taken = ~neg & ~eq;
      BR_BLTZ: taken = neg;
      BR_BGEZ: taken = ~neg;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/br_eq_cmp.sv
// Bitwise equality comparator: eq_o is high when both operands match in every bit.
module br_eq_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o
);

  logic [W-1:0] bit_eq;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign bit_eq[gi] = ~(a_i[gi] ^ b_i[gi]);
  end

  assign eq_o = &bit_eq;

endmodule

// File: rtl/br_target_adder.sv
// Branch target: pc + 4 + (sign-extended word offset << 2), wrapping at DATA_W bits.
module br_target_adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] pc_i,
  input  logic [15:0]       imm_i,
  output logic [DATA_W-1:0] target_o
);

  logic [DATA_W-1:0] offset;

  assign offset   = {{(DATA_W-18){imm_i[15]}}, imm_i, 2'b00};
  assign target_o = pc_i + DATA_W'(4) + offset;

endmodule

// File: rtl/branch_cmp_ctrl.sv
// ID-stage branch resolution controller: waits for forwarded operands, evaluates the
// branch condition, pulses a PC redirect and keeps branch/taken statistics.
module branch_cmp_ctrl
  import mips_br_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_hold,
  input  logic              br_valid,
  input  logic [2:0]        br_op,
  input  logic              rs_ready,
  input  logic              rt_ready,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [DATA_W-1:0] pc_id,
  input  logic [15:0]       imm16,
  output logic              stall_id,
  output logic              redirect_vld,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              br_taken,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [DATA_W-1:0] FALLTHRU_STEP = DATA_W'(8);

  br_state_e         state_q, state_d;
  br_op_e            op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [15:0]       imm_q, imm_d;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  br_op_e            op_in;
  logic              eq;
  logic              eval_taken;
  logic [DATA_W-1:0] target;

  assign op_in = br_op_e'(br_op);

  br_eq_cmp #(
    .W (DATA_W)
  ) u_eq_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .eq_o (eq)
  );

  br_target_adder #(
    .DATA_W (DATA_W)
  ) u_target (
    .pc_i     (pc_q),
    .imm_i    (imm_q),
    .target_o (target)
  );

  assign eval_taken = br_resolve(op_q, eq, a_q[DATA_W-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= BR_BEQ;
      a_q           <= '0;
      b_q           <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      taken_q       <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      taken_q       <= taken_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    taken_d       = taken_q;
    redirect_pc_d = redirect_pc_q;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    stall_id      = 1'b0;
    redirect_vld  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          stall_id = 1'b1;
          if (!pipe_hold) begin
            op_d    = op_in;
            a_d     = rs_val;
            b_d     = br_needs_rt(op_in) ? rt_val : '0;
            pc_d    = pc_id;
            imm_d   = imm16;
            state_d = (rs_ready && (rt_ready || !br_needs_rt(op_in))) ? ST_EVAL : ST_WAIT;
          end
        end
      end

      // Operands are re-sampled each cycle so the value latched is the one present when ready.
      ST_WAIT: begin
        stall_id = 1'b1;
        if (!pipe_hold) begin
          a_d = rs_val;
          b_d = br_needs_rt(op_q) ? rt_val : '0;
          if (rs_ready && (rt_ready || !br_needs_rt(op_q))) begin
            state_d = ST_EVAL;
          end
        end
      end

      ST_EVAL: begin
        stall_id = 1'b1;
        if (!pipe_hold) begin
          taken_d       = eval_taken;
          redirect_pc_d = eval_taken ? target : (pc_q + FALLTHRU_STEP);
          state_d       = ST_DONE;
        end
      end

      // br_valid still reflects the branch just resolved, so it must not start a new one here.
      ST_DONE: begin
        if (!pipe_hold) begin
          redirect_vld = 1'b1;
          br_cnt_d     = br_cnt_q + CNT_W'(1);
          taken_cnt_d  = taken_cnt_q + CNT_W'(taken_q);
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign redirect_pc = redirect_pc_q;
  assign br_taken    = taken_q;
  assign br_cnt      = br_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// Self-checking bench for branch_cmp_ctrl: directed cases plus randomized branches
// checked against an arithmetic reference model of the branch rules.
module tb_branch_cmp_ctrl;

  localparam int CNT_W = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_hold;
  logic        br_valid;
  logic [2:0]  br_op;
  logic        rs_ready;
  logic        rt_ready;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc_id;
  logic [15:0] imm16;
  logic        stall_id;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        br_taken;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  int tests = 0;
  int fails = 0;
  int cnt_m = 0;
  int tk_m  = 0;
  logic [31:0] last_pc;
  logic        last_taken;

  always #5 clk = ~clk;

  branch_cmp_ctrl #(
    .DATA_W (32),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_hold    (pipe_hold),
    .br_valid     (br_valid),
    .br_op        (br_op),
    .rs_ready     (rs_ready),
    .rt_ready     (rt_ready),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .pc_id        (pc_id),
    .imm16        (imm16),
    .stall_id     (stall_id),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .br_taken     (br_taken),
    .br_cnt       (br_cnt),
    .taken_cnt    (taken_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_taken(input int op, input logic [31:0] rs, input logic [31:0] rt);
    case (op)
      0: return rs == rt;
      1: return rs != rt;
      2: return $signed(rs) <= 0;
      3: return $signed(rs) > 0;
      4: return $signed(rs) < 0;
      5: return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = $signed(imm);
    return pc + 32'd4 + 32'(off * 4);
  endfunction

  // One branch: nwait not-ready cycles, he hold cycles in EVAL, hd hold cycles in DONE.
  task automatic run_branch(input int op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] pc, input logic [15:0] imm,
                            input int nwait, input int he, input int hd);
    int L;
    logic exp_taken;
    logic [31:0] exp_pc;
    bit need_rt;
    L = nwait + he + hd + 2;
    exp_taken = model_taken(op, rs, rt);
    exp_pc = exp_taken ? model_target(pc, imm) : pc + 32'd8;
    need_rt = (op < 2);
    for (int i = 0; i <= L; i++) begin
      @(negedge clk);
      br_valid = 1'b1;
      br_op = 3'(op);
      pc_id = pc;
      imm16 = imm;
      if (i < nwait) begin
        rs_val = $urandom;
        rt_val = $urandom;
        if (need_rt) begin
          case ($urandom_range(2))
            0: begin rs_ready = 1'b0; rt_ready = 1'b1; end
            1: begin rs_ready = 1'b1; rt_ready = 1'b0; end
            default: begin rs_ready = 1'b0; rt_ready = 1'b0; end
          endcase
        end else begin
          rs_ready = 1'b0;
          rt_ready = 1'($urandom);
        end
      end else begin
        rs_val = rs;
        rt_val = rt;
        rs_ready = 1'b1;
        rt_ready = (need_rt || op > 5) ? 1'b1 : 1'($urandom);
      end
      pipe_hold = ((i >= nwait + 1) && (i <= nwait + he)) ||
                  ((i >= nwait + he + 2) && (i <= nwait + he + 1 + hd));
      #1;
      chk($sformatf("stall_id op%0d cyc%0d", op, i), 32'(stall_id), 32'(i < nwait + he + 2));
      chk($sformatf("redirect_vld op%0d cyc%0d", op, i), 32'(redirect_vld), 32'(i == L));
      if (i == L) begin
        chk("redirect_pc", redirect_pc, exp_pc);
        chk("br_taken", 32'(br_taken), 32'(exp_taken));
        chk("br_cnt_before", 32'(br_cnt), 32'(cnt_m));
        last_pc = redirect_pc;
        last_taken = br_taken;
      end
      $display("[TB] cyc %0d op=%0d stall=%0b vld=%0b pc=%h taken=%0b",
               i, op, stall_id, redirect_vld, redirect_pc, br_taken);
    end
    cnt_m = (cnt_m + 1) % CNT_MOD;
    if (exp_taken) tk_m = (tk_m + 1) % CNT_MOD;
    @(negedge clk);
    br_valid = 1'b0;
    rs_ready = 1'b0;
    rt_ready = 1'b0;
    pipe_hold = 1'b0;
    #1;
    chk("redirect_vld_after", 32'(redirect_vld), 32'd0);
    chk("stall_idle", 32'(stall_id), 32'd0);
    chk("br_cnt", 32'(br_cnt), 32'(cnt_m));
    chk("taken_cnt", 32'(taken_cnt), 32'(tk_m));
  endtask

  initial begin
    logic [31:0] r_rs, r_rt;
    reset = 1'b1;
    pipe_hold = 1'b0;
    br_valid = 1'b0;
    br_op = 3'd0;
    rs_ready = 1'b0;
    rt_ready = 1'b0;
    rs_val = '0;
    rt_val = '0;
    pc_id = '0;
    imm16 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_vld", 32'(redirect_vld), 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_taken", 32'(br_taken), 32'd0);
    chk("rst_br_cnt", 32'(br_cnt), 32'd0);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_branch(0, 32'h1234, 32'h1234, 32'h3000, 16'h0004, 0, 0, 0);
    chk("beq_pc", last_pc, 32'h0000_3014);
    chk("beq_taken", 32'(last_taken), 32'd1);
    run_branch(1, 32'd5, 32'd5, 32'h3000, 16'hFFFF, 0, 0, 0);
    chk("bne_pc", last_pc, 32'h0000_3008);
    chk("bne_taken", 32'(last_taken), 32'd0);
    run_branch(3, 32'd1, 32'd0, 32'h3000, 16'h0010, 3, 0, 0);
    chk("bgtz1_taken", 32'(last_taken), 32'd1);
    run_branch(3, 32'd0, 32'd0, 32'h3000, 16'h0010, 3, 0, 0);
    chk("bgtz0_taken", 32'(last_taken), 32'd0);
    run_branch(2, 32'h8000_0000, 32'd0, 32'hFFFF_FFF0, 16'h0004, 0, 0, 0);
    chk("blez_wrap_pc", last_pc, 32'h0000_0004);
    run_branch(5, 32'd0, 32'd0, 32'hFFFF_FFF0, 16'h0004, 0, 0, 0);
    chk("bgez_wrap_pc", last_pc, 32'h0000_0004);
    run_branch(0, 32'd7, 32'd7, 32'h0000_0100, 16'h0008, 0, 2, 0);
    run_branch(4, 32'hFFFF_FFFF, 32'd0, 32'h0000_0200, 16'hFFF0, 1, 1, 2);
    run_branch(6, 32'd3, 32'd3, 32'h0000_0400, 16'h0001, 0, 0, 0);
    chk("rsv_pc", last_pc, 32'h0000_0408);

    for (int n = 0; n < 60; n++) begin
      r_rt = $urandom;
      case ($urandom_range(3))
        0: r_rs = 32'd0;
        1: r_rs = r_rt;
        default: r_rs = $urandom;
      endcase
      run_branch(int'($urandom_range(7)), r_rs, r_rt, $urandom, 16'($urandom),
                 int'($urandom_range(3)), int'($urandom_range(2)), int'($urandom_range(1)));
    end

    // Reset while a branch waits for its operand: nothing may be redirected or counted.
    @(negedge clk);
    br_valid = 1'b1;
    br_op = 3'd3;
    rs_ready = 1'b0;
    rs_val = 32'd1;
    #1;
    chk("rstw_stall0", 32'(stall_id), 32'd1);
    @(negedge clk);
    #1;
    chk("rstw_stall1", 32'(stall_id), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    br_valid = 1'b0;
    #1;
    cnt_m = 0;
    tk_m = 0;
    chk("rstw_stall", 32'(stall_id), 32'd0);
    chk("rstw_vld", 32'(redirect_vld), 32'd0);
    chk("rstw_br_cnt", 32'(br_cnt), 32'd0);
    chk("rstw_taken_cnt", 32'(taken_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("rstw_no_redirect", 32'(redirect_vld), 32'd0);
    end

    for (int n = 0; n < CNT_MOD - 1; n++) begin
      r_rs = $urandom;
      run_branch(int'($urandom_range(5)), r_rs, r_rs ^ 32'($urandom_range(1)),
                 $urandom, 16'($urandom), 0, 0, 0);
    end
    chk("pre_wrap_br_cnt", 32'(br_cnt), 32'(CNT_MOD - 1));
    run_branch(1, 32'd1, 32'd2, 32'h0000_1000, 16'h0002, 0, 0, 0);
    chk("wrap_br_cnt", 32'(br_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
